// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use, branch-flush and mult/div-busy stalls.
// Optional HAZARD_PERF_EN adds stall_cycles/flush_cycles performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MD_LATENCY   = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_uses_rt,
   input  logic       ID_md_start,
   input  logic       ID_md_read,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rt,
   input  logic       EX_branch_taken,
   output logic       PC_Write,
   output logic       IF_ID_Write,
   output logic       IF_ID_clear,
   output logic       ID_EX_clear,
   output logic       md_busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles
`endif
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
   localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
   localparam logic [5:0] MD_INIT     = 6'(MD_LATENCY);

   state_t     state, state_n;
   logic [2:0] flush_cnt, flush_cnt_n;
   logic [5:0] md_cnt;

   logic lu_hit, md_hit;
   logic flush_now, lu_stall, md_stall, md_accept;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= '0;
      end else begin
         state     <= state_n;
         flush_cnt <= flush_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      flush_cnt_n = flush_cnt;
      unique case (state)
         RUN: begin
            if (EX_branch_taken && MULTI_FLUSH) begin
               state_n     = FLUSH;
               flush_cnt_n = FLUSH_INIT;
            end
         end
         FLUSH: begin
            if (flush_cnt == 3'd1) begin
               state_n     = RUN;
               flush_cnt_n = '0;
            end else begin
               flush_cnt_n = flush_cnt - 3'd1;
            end
         end
         default: begin
            state_n     = RUN;
            flush_cnt_n = '0;
         end
      endcase
   end

   assign md_busy = (md_cnt != '0);

   assign lu_hit = EX_MemRead && (EX_rt != '0) &&
                   ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
   assign md_hit = md_busy && (ID_md_read || ID_md_start);

   // Mutually exclusive by construction so the priority decoder stays unique.
   assign flush_now = !reset && ((state == FLUSH) || EX_branch_taken);
   assign lu_stall  = !reset && !flush_now && lu_hit;
   assign md_stall  = !reset && !flush_now && !lu_hit && md_hit;
   assign md_accept = !reset && !flush_now && !lu_stall && !md_stall &&
                      ID_md_start;

   always_ff @(posedge clock) begin
      if (reset) begin
         md_cnt <= '0;
      end else if (md_accept) begin
         md_cnt <= MD_INIT;
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - 6'd1;
      end
   end

   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_clear = 1'b0;
      ID_EX_clear = 1'b0;
      unique case (1'b1)
         reset: begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_clear = 1'b1;
            ID_EX_clear = 1'b1;
         end
         flush_now: begin
            IF_ID_Write = 1'b0;
            IF_ID_clear = 1'b1;
            ID_EX_clear = 1'b1;
         end
         lu_stall, md_stall: begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_clear = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         stall_cycles <= stall_cycles + 32'(lu_stall || md_stall);
         flush_cycles <= flush_cycles + 32'(flush_now);
      end
   end
`endif

endmodule
